// File: rtl/acc_drain_pkg.sv
// acc_drain shared types and sizing helpers.
// Drain FSM states and default column geometry.
package acc_drain_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM
    } state_e;

    localparam int DEF_N   = 4;
    localparam int DEF_DW  = 16;
    localparam int DEF_AW  = 64;
    localparam int DEF_SW  = 6;

    // Index width that stays legal for a single-element column.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W = idx_w(DEF_N);

endpackage

// File: rtl/acc_drain_if.sv
// Output stream bundle of the accumulator drain.
// Word, index and last flag travel under one valid/ready pair.
interface acc_drain_if
    import acc_drain_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DW,
    parameter int IDX_W      = acc_drain_pkg::IDX_W
);
    logic signed [DATA_WIDTH-1:0] data_o;
    logic                         valid_o;
    logic                         ready_i;
    logic [IDX_W-1:0]             idx_o;
    logic                         last_o;

    modport master (
        output data_o, valid_o, idx_o, last_o,
        input  ready_i
    );

    modport slave (
        input  data_o, valid_o, idx_o, last_o,
        output ready_i
    );

endinterface

// File: rtl/acc_drain_requant.sv
// Requantizer: arithmetic shift, optional ReLU, saturate.
// Purely combinational; all intermediates at accumulator width.
module acc_requant #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 64,
    parameter int SHIFT_W    = 6
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    input  logic        [SHIFT_W-1:0]    shift,
    input  logic                         relu_en,
    output logic signed [DATA_WIDTH-1:0] q
);

    localparam logic signed [ACC_WIDTH-1:0] MAXV =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MINV =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] s;
    logic signed [ACC_WIDTH-1:0] r;

    // Shift floors toward -inf; oversize shifts leave only sign fill.
    always_comb begin
        s = acc >>> shift;
        r = (relu_en && (s < 0)) ? '0 : s;
        if (r > MAXV)
            q = MAXV[DATA_WIDTH-1:0];
        else if (r < MINV)
            q = MINV[DATA_WIDTH-1:0];
        else
            q = r[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/acc_drain.sv
// Column drain: snapshot N accumulators, requantize, stream out.
// FSM IDLE->LOAD->STREAM; one word per cycle under valid/ready.
module acc_drain
    import acc_drain_pkg::*;
#(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 64,
    parameter int SHIFT_W    = 6
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start_i,
    input  logic [SHIFT_W-1:0]     shift_i,
    input  logic                   relu_en_i,
    input  logic [N*ACC_WIDTH-1:0] acc_i,
    output logic                   busy_o,
    output logic                   done_o,
    acc_drain_if.master            bus
);

    localparam int IW = idx_w(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_e state, state_n;

    logic signed [ACC_WIDTH-1:0] snap [N];
    logic [SHIFT_W-1:0] snap_shift;
    logic               snap_relu;

    logic [IW-1:0] idx, idx_n, sel;
    logic          snap_en, ld, valid_n, done_n;
    logic signed [DATA_WIDTH-1:0] q;

    acc_requant #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SHIFT_W    (SHIFT_W)
    ) u_rq (
        .acc     (snap[sel]),
        .shift   (snap_shift),
        .relu_en (snap_relu),
        .q       (q)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    // Next state and datapath strobes.
    always_comb begin
        state_n = state;
        snap_en = 1'b0;
        ld      = 1'b0;
        sel     = '0;
        idx_n   = idx;
        valid_n = bus.valid_o;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    snap_en = 1'b1;
                    idx_n   = '0;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                ld      = 1'b1;
                idx_n   = '0;
                valid_n = 1'b1;
                state_n = STREAM;
            end
            STREAM: begin
                if (bus.valid_o && bus.ready_i) begin
                    if (idx == LAST) begin
                        valid_n = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ld    = 1'b1;
                        sel   = idx + IW'(1);
                        idx_n = idx + IW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Snapshot of accumulators and requant settings at start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < N; k++) snap[k] <= '0;
            snap_shift <= '0;
            snap_relu  <= 1'b0;
        end else if (snap_en) begin
            for (int k = 0; k < N; k++)
                snap[k] <= acc_i[k*ACC_WIDTH +: ACC_WIDTH];
            snap_shift <= shift_i;
            snap_relu  <= relu_en_i;
        end
    end

    // Output word, index, flags; held while the consumer stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.data_o  <= '0;
            bus.valid_o <= 1'b0;
            bus.last_o  <= 1'b0;
            idx         <= '0;
            done_o      <= 1'b0;
        end else begin
            idx         <= idx_n;
            bus.valid_o <= valid_n;
            done_o      <= done_n;
            if (ld) begin
                bus.data_o <= q;
                bus.last_o <= (sel == LAST);
            end else if (done_n) begin
                bus.last_o <= 1'b0;
            end
        end
    end

    assign bus.idx_o = idx;
    assign busy_o    = (state != IDLE);

endmodule

// File: tb/tb_acc_drain.sv
// Directed bench for acc_drain (N=4, DW=16, AW=64).
// Each task drives one scenario and checks its own results.
module tb_acc_drain;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start_i = 1'b0;
    logic [5:0]   shift_i = '0;
    logic         relu_en_i = 1'b0;
    logic [255:0] acc_i = '0;
    logic         busy_o, done_o;

    acc_drain_if #(.DATA_WIDTH(16), .IDX_W(2)) bus ();

    acc_drain dut (
        .clk       (clk),
        .rstn      (rstn),
        .start_i   (start_i),
        .shift_i   (shift_i),
        .relu_en_i (relu_en_i),
        .acc_i     (acc_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int t_start;

    logic signed [15:0] got_data [16];
    logic [1:0]         got_idx  [16];
    logic               got_last [16];
    int                 got_cyc  [16];
    int ngot, ndone, unstable, done_cyc;

    function automatic logic [255:0] pk(input longint a0, a1, a2, a3);
        return {64'(a3), 64'(a2), 64'(a1), 64'(a0)};
    endfunction

    task automatic kick(input logic [255:0] a, input logic [5:0] sh,
                        input logic rl);
        acc_i     = a;
        shift_i   = sh;
        relu_en_i = rl;
        start_i   = 1'b1;
        t_start   = cyc;
        @(posedge clk); #1;
        start_i   = 1'b0;
    endtask

    // Consume a stream with a per-valid-cycle ready pattern (1 after it).
    task automatic drain(input logic [15:0] rpat, input int rlen);
        int ri = 0;
        int tail = -1;
        logic stall = 1'b0;
        logic [15:0] hd = '0;
        logic [1:0]  hi = '0;
        logic        hl = 1'b0;
        ngot = 0; ndone = 0; unstable = 0; done_cyc = -1;
        for (int k = 0; k < 60; k++) begin
            bus.ready_i = (bus.valid_o && ri < rlen) ? rpat[ri] : 1'b1;
            if (bus.valid_o) ri++;
            if (stall && (bus.data_o !== hd || bus.idx_o !== hi ||
                          bus.last_o !== hl))
                unstable++;
            stall = bus.valid_o && !bus.ready_i;
            hd = bus.data_o; hi = bus.idx_o; hl = bus.last_o;
            if (bus.valid_o && bus.ready_i) begin
                if (ngot < 16) begin
                    got_data[ngot] = bus.data_o;
                    got_idx[ngot]  = bus.idx_o;
                    got_last[ngot] = bus.last_o;
                    got_cyc[ngot]  = cyc;
                end
                ngot++;
            end
            if (done_o) begin
                ndone++;
                done_cyc = cyc;
                if (tail < 0) tail = 3;
            end
            @(posedge clk); #1;
            if (tail == 0) break;
            if (tail > 0) tail--;
        end
        bus.ready_i = 1'b1;
    endtask

    task automatic test_reset;
        #1;
        total += 6;
        if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.valid_o); end
        if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy_o); end
        if (done_o !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done_o); end
        if (bus.data_o !== 16'd0) begin bad++; $display("FAIL rst_data got=%0d want=0", bus.data_o); end
        if (bus.idx_o !== 2'd0) begin bad++; $display("FAIL rst_idx got=%0d want=0", bus.idx_o); end
        if (bus.last_o !== 1'b0) begin bad++; $display("FAIL rst_last got=%b want=0", bus.last_o); end
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic signed [15:0] e [4] = '{16'sd100, -16'sd200, 16'sd300, -16'sd400};
        kick(pk(100, -200, 300, -400), 6'd0, 1'b0);
        total += 2;
        if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL load_valid got=%b want=0", bus.valid_o); end
        if (busy_o !== 1'b1) begin bad++; $display("FAIL load_busy got=%b want=1", busy_o); end
        drain('0, 0);
        total++;
        if (ngot !== 4) begin bad++; $display("FAIL basic_count got=%0d want=4", ngot); end
        for (int i = 0; i < 4; i++) begin
            total += 3;
            if (got_data[i] !== e[i]) begin bad++; $display("FAIL basic_data%0d got=%0d want=%0d", i, got_data[i], e[i]); end
            if (got_cyc[i] !== t_start + 2 + i) begin bad++; $display("FAIL basic_cyc%0d got=%0d want=%0d", i, got_cyc[i], t_start + 2 + i); end
            if (got_last[i] !== (i == 3)) begin bad++; $display("FAIL basic_last%0d got=%b want=%b", i, got_last[i], i == 3); end
        end
        total += 3;
        if (done_cyc !== t_start + 6) begin bad++; $display("FAIL basic_done_cyc got=%0d want=%0d", done_cyc, t_start + 6); end
        if (ndone !== 1) begin bad++; $display("FAIL basic_ndone got=%0d want=1", ndone); end
        if (busy_o !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b want=0", busy_o); end
    endtask

    task automatic test_saturate;
        logic signed [15:0] e0 [4] = '{16'sd32767, -16'sd32768, 16'sd32767, -16'sd5};
        logic signed [15:0] e2 [4] = '{16'sd17500, -16'sd17500, 16'sd17500, -16'sd2};
        kick(pk(70000, -70000, 70000, -5), 6'd0, 1'b0);
        drain('0, 0);
        total++;
        if (ngot !== 4) begin bad++; $display("FAIL sat_count got=%0d want=4", ngot); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_data[i] !== e0[i]) begin bad++; $display("FAIL sat_data%0d got=%0d want=%0d", i, got_data[i], e0[i]); end
        end
        kick(pk(70000, -70000, 70000, -5), 6'd2, 1'b0);
        drain('0, 0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_data[i] !== e2[i]) begin bad++; $display("FAIL shift2_data%0d got=%0d want=%0d", i, got_data[i], e2[i]); end
        end
    endtask

    task automatic test_relu_maxshift;
        logic signed [15:0] e [4] = '{-16'sd1, -16'sd1, 16'sd0, -16'sd1};
        kick(pk(-5, -1, 7, -7), 6'd63, 1'b0);
        drain('0, 0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_data[i] !== e[i]) begin bad++; $display("FAIL sh63_data%0d got=%0d want=%0d", i, got_data[i], e[i]); end
        end
        kick(pk(-5, -1, 7, -7), 6'd63, 1'b1);
        drain('0, 0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_data[i] !== 16'sd0) begin bad++; $display("FAIL relu_data%0d got=%0d want=0", i, got_data[i]); end
        end
    endtask

    task automatic test_backpressure;
        logic signed [15:0] e [4] = '{16'sd11, -16'sd22, 16'sd33, -16'sd44};
        kick(pk(11, -22, 33, -44), 6'd0, 1'b0);
        drain(16'b1101001, 7);
        total += 3;
        if (ngot !== 4) begin bad++; $display("FAIL bp_count got=%0d want=4", ngot); end
        if (unstable !== 0) begin bad++; $display("FAIL bp_stable got=%0d want=0", unstable); end
        if (ndone !== 1) begin bad++; $display("FAIL bp_ndone got=%0d want=1", ndone); end
        for (int i = 0; i < 4; i++) begin
            total += 2;
            if (got_idx[i] !== 2'(i)) begin bad++; $display("FAIL bp_idx%0d got=%0d want=%0d", i, got_idx[i], i); end
            if (got_data[i] !== e[i]) begin bad++; $display("FAIL bp_data%0d got=%0d want=%0d", i, got_data[i], e[i]); end
        end
    endtask

    task automatic test_ignore_start;
        logic signed [15:0] e [4] = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        int nv = 0;
        kick(pk(1, 2, 3, 4), 6'd0, 1'b0);
        acc_i = pk(9, 9, 9, 9);
        @(posedge clk); #1;
        bus.ready_i = 1'b0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        drain('0, 0);
        total += 2;
        if (ngot !== 4) begin bad++; $display("FAIL ign_count got=%0d want=4", ngot); end
        if (ndone !== 1) begin bad++; $display("FAIL ign_ndone got=%0d want=1", ndone); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_data[i] !== e[i]) begin bad++; $display("FAIL ign_data%0d got=%0d want=%0d", i, got_data[i], e[i]); end
        end
        for (int k = 0; k < 5; k++) begin
            if (bus.valid_o || busy_o) nv++;
            @(posedge clk); #1;
        end
        total++;
        if (nv !== 0) begin bad++; $display("FAIL ign_second got=%0d want=0", nv); end
    endtask

    task automatic test_reset_abort;
        logic signed [15:0] e [4] = '{-16'sd7, 16'sd8, -16'sd9, 16'sd10};
        kick(pk(500, 600, 700, 800), 6'd0, 1'b0);
        bus.ready_i = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        bus.ready_i = 1'b0;
        total++;
        if (bus.idx_o !== 2'd2) begin bad++; $display("FAIL abort_pre_idx got=%0d want=2", bus.idx_o); end
        rstn = 1'b0;
        #1;
        total += 3;
        if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b want=0", bus.valid_o); end
        if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy_o); end
        if (done_o !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done_o); end
        @(negedge clk) rstn = 1'b1;
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        kick(pk(-7, 8, -9, 10), 6'd0, 1'b0);
        drain('0, 0);
        total++;
        if (ngot !== 4) begin bad++; $display("FAIL abort_count got=%0d want=4", ngot); end
        for (int i = 0; i < 4; i++) begin
            total += 2;
            if (got_idx[i] !== 2'(i)) begin bad++; $display("FAIL abort_idx%0d got=%0d want=%0d", i, got_idx[i], i); end
            if (got_data[i] !== e[i]) begin bad++; $display("FAIL abort_data%0d got=%0d want=%0d", i, got_data[i], e[i]); end
        end
    endtask

    initial begin
        bus.ready_i = 1'b1;
        test_reset();
        test_basic();
        test_saturate();
        test_relu_maxshift();
        test_backpressure();
        test_ignore_start();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
